// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports, the shared memory port and the status
// flags of mem_port_arbiter.
interface mem_port_arbiter_if;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dack;

  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        iack;

  logic        lreq;
  logic        lwe;
  logic [31:0] laddr;
  logic [31:0] lwdata;
  logic [31:0] lrdata;
  logic        lack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        busy;
  logic        timeout_err;

  // Arbiter side.
  modport slave (
    input  dreq, dwe, daddr, dwdata, ireq, iaddr, lreq, lwe, laddr, lwdata,
           mem_rdata, mem_ready,
    output drdata, dack, irdata, iack, lrdata, lack,
           mem_en, mem_we, mem_addr, mem_wdata, busy, timeout_err
  );

  // Environment side: requesters plus the memory itself.
  modport master (
    output dreq, dwe, daddr, dwdata, ireq, iaddr, lreq, lwe, laddr, lwdata,
           mem_rdata, mem_ready,
    input  drdata, dack, irdata, iack, lrdata, lack,
           mem_en, mem_we, mem_addr, mem_wdata, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between loader, data and fetch requesters: loader wins,
// data/fetch alternate round-robin, and each access is bounded by TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_DATA  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  // Counter holds the number of completed ACCESS cycles that saw no mem_ready.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;  // 1: fetch wins the next data/fetch tie
  logic        terr_q, terr_d;
  logic [31:0] drdata_q, drdata_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] lrdata_q, lrdata_d;
  logic [31:0] resp;
  logic        done_now;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    terr_d   = terr_q;
    drdata_d = drdata_q;
    irdata_d = irdata_q;
    lrdata_d = lrdata_q;
    resp     = '0;
    done_now = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.lreq) begin
          owner_d = OWN_LOAD;
          addr_d  = bus.laddr;
          wdata_d = bus.lwdata;
          we_d    = bus.lwe;
          state_d = S_ACCESS;
        end else if (bus.dreq && !(bus.ireq && ptr_q)) begin
          owner_d = OWN_DATA;
          addr_d  = bus.daddr;
          wdata_d = bus.dwdata;
          we_d    = bus.dwe;
          ptr_d   = 1'b1;
          state_d = S_ACCESS;
        end else if (bus.ireq) begin
          owner_d = OWN_FETCH;
          addr_d  = bus.iaddr;
          wdata_d = '0;
          we_d    = 1'b0;
          ptr_d   = 1'b0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // mem_ready is checked first so a last-cycle response still counts as success.
        if (bus.mem_ready) begin
          resp     = we_q ? '0 : bus.mem_rdata;
          done_now = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          terr_d   = 1'b1;
          done_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        if (done_now) begin
          state_d = S_DONE;
          case (owner_q)
            OWN_DATA:  drdata_d = resp;
            OWN_FETCH: irdata_d = resp;
            default:   lrdata_d = resp;
          endcase
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the latched request registers are reset too, so mem_addr/mem_wdata read zero the moment reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_DATA;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      terr_q   <= 1'b0;
      drdata_q <= '0;
      irdata_q <= '0;
      lrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      terr_q   <= terr_d;
      drdata_q <= drdata_d;
      irdata_q <= irdata_d;
      lrdata_q <= lrdata_d;
    end
  end

  assign bus.mem_en      = (state_q == S_ACCESS);
  assign bus.mem_we      = (state_q == S_ACCESS) && we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;

  assign bus.dack        = (state_q == S_DONE) && (owner_q == OWN_DATA);
  assign bus.iack        = (state_q == S_DONE) && (owner_q == OWN_FETCH);
  assign bus.lack        = (state_q == S_DONE) && (owner_q == OWN_LOAD);
  assign bus.drdata      = drdata_q;
  assign bus.irdata      = irdata_q;
  assign bus.lrdata      = lrdata_q;

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requests are predicted into a queue in
// service order; a memory responder and an ack monitor check them independently.
module tb_mem_port_arbiter;

  localparam int TO     = 6;
  localparam int NBATCH = 150;
  localparam int BOUND  = 3 * (TO + 4) + 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // port index: 0 data, 1 fetch, 2 loader
  typedef struct {
    int          port;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          tmo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] exp_rd [3];
  bit          exp_terr;
  bit          fav_fetch;
  int          acc_cycles;

  logic [31:0] op_addr  [3];
  logic [31:0] op_wdata [3];
  bit          op_we    [3];
  int          op_lat   [3];  // ACCESS cycle carrying mem_ready; 0 or >TO means never

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // Loader first; otherwise the port the round-robin pointer favours.
  function automatic int pick(input bit [2:0] pend, input bit ff);
    if (pend[2]) return 2;
    if (pend[0] && pend[1]) return ff ? 1 : 0;
    return pend[0] ? 0 : 1;
  endfunction

  function automatic int rand_lat();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return TO;
      2:       return 1;
      3:       return TO + 2;
      default: return int'($urandom_range(1, TO));
    endcase
  endfunction

  task automatic randomize_ops();
    for (int p = 0; p < 3; p++) begin
      op_addr[p]  = 32'($urandom_range(0, 7)) << 2;
      op_we[p]    = 1'($urandom_range(0, 1));
      op_wdata[p] = $urandom;
      op_lat[p]   = rand_lat();
    end
  endtask

  // Predict the service order and responses, then raise the requests.
  // With late=1 (mask 3'b011 only) the loader is raised during the first ack.
  task automatic start_batch(input bit [2:0] mask, input bit late);
    bit [2:0] pend;
    int       p;
    exp_t     e;
    pend = late ? (mask & 3'b011) : mask;
    for (int k = 0; k < 3; k++) begin
      if (pend == 3'b000) break;
      p = pick(pend, fav_fetch);
      pend[p] = 1'b0;
      if (late && k == 0) pend[2] = 1'b1;
      if (p == 0) fav_fetch = 1'b1;
      else if (p == 1) fav_fetch = 1'b0;
      e.port  = p;
      e.addr  = op_addr[p];
      e.we    = (p != 1) && op_we[p];
      e.wdata = op_wdata[p];
      e.lat   = op_lat[p];
      e.tmo   = (op_lat[p] == 0) || (op_lat[p] > TO);
      if (e.we) begin
        e.rdata = '0;
        if (!e.tmo) ref_mem[e.addr] = e.wdata;
      end else begin
        e.rdata = e.tmo ? 32'h0 : ref_read(e.addr);
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.daddr  = op_addr[0];
    bus.dwe    = op_we[0];
    bus.dwdata = op_wdata[0];
    bus.iaddr  = op_addr[1];
    bus.laddr  = op_addr[2];
    bus.lwe    = op_we[2];
    bus.lwdata = op_wdata[2];
    bus.dreq   = mask[0];
    bus.ireq   = mask[1];
    bus.lreq   = mask[2] && !late;
  endtask

  // Drop each request on its ack; bounded wait for the whole batch.
  task automatic finish_batch(input bit late);
    bit l_pending;
    int n;
    l_pending = late;
    for (n = 0; n < BOUND; n++) begin
      @(negedge clk);
      if (bus.dack) bus.dreq = 1'b0;
      if (bus.iack) bus.ireq = 1'b0;
      if (bus.lack) bus.lreq = 1'b0;
      if (l_pending && (bus.dack || bus.iack)) begin
        bus.lreq  = 1'b1;
        l_pending = 1'b0;
      end
      if (!bus.dreq && !bus.ireq && !bus.lreq && !l_pending && sb_q.size() == 0) break;
    end
    check("batch_done", 32'(n < BOUND), 32'd1);
    if (n >= BOUND) begin
      bus.dreq = 1'b0;
      bus.ireq = 1'b0;
      bus.lreq = 1'b0;
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_en"},      32'(bus.mem_en), 32'd0);
    check({tag, "_mem_we"},      32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"},    bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"},   bus.mem_wdata, 32'd0);
    check({tag, "_acks"},        32'({bus.lack, bus.iack, bus.dack}), 32'd0);
    check({tag, "_busy"},        32'(bus.busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    check({tag, "_drdata"},      bus.drdata, 32'd0);
    check({tag, "_irdata"},      bus.irdata, 32'd0);
    check({tag, "_lrdata"},      bus.lrdata, 32'd0);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, then releases it.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    bus.dreq  = 1'b0;
    bus.ireq  = 1'b0;
    bus.lreq  = 1'b0;
    sb_q.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_rd[2] = '0;
    exp_terr  = 1'b0;
    fav_fetch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Memory responder: answers on the planned ACCESS cycle, asserts stray
  // mem_ready outside ACCESS, and checks the request is held stable.
  initial begin
    bit   in_txn;
    bit   bogus;
    int   cur_lat;
    exp_t cur;
    in_txn        = 1'b0;
    bogus         = 1'b0;
    cur_lat       = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_txn        = 1'b0;
        bus.mem_ready = 1'b0;
      end else if (bus.mem_en) begin
        if (!in_txn) begin
          in_txn     = 1'b1;
          acc_cycles = 0;
          if (sb_q.size() == 0) begin
            check("unexpected_access", 32'd1, 32'd0);
            bogus   = 1'b1;
            cur_lat = 1;
          end else begin
            bogus   = 1'b0;
            cur     = sb_q[0];
            cur_lat = cur.lat;
          end
        end
        acc_cycles++;
        if (!bogus) begin
          check("mem_addr", bus.mem_addr, cur.addr);
          check("mem_we", 32'(bus.mem_we), 32'(cur.we));
          if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
        end
        if (acc_cycles == cur_lat) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) begin
            mem_store[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = $urandom;
          end else begin
            bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                            : mem_default(bus.mem_addr);
          end
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        in_txn        = 1'b0;
        bus.mem_ready = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Ack monitor: pops the scoreboard on each ack and checks held outputs every cycle.
  initial begin
    exp_t       e;
    logic [2:0] acks;
    logic [2:0] want;
    forever begin
      @(negedge clk);
      if (!reset) begin
        acks = {bus.lack, bus.iack, bus.dack};
        if (acks != 3'b000) begin
          if (sb_q.size() == 0) begin
            check("spurious_ack", 32'(acks), 32'd0);
          end else begin
            e    = sb_q.pop_front();
            want = 3'(1 << e.port);
            check("ack_owner", 32'(acks), 32'(want));
            exp_rd[e.port] = e.rdata;
            exp_terr       = exp_terr | e.tmo;
            check("access_cycles", 32'(acc_cycles), 32'(e.tmo ? TO : e.lat));
            check("busy_in_done", 32'(bus.busy), 32'd1);
            check("mem_en_in_done", 32'(bus.mem_en), 32'd0);
          end
        end
        check("drdata", bus.drdata, exp_rd[0]);
        check("irdata", bus.irdata, exp_rd[1]);
        check("lrdata", bus.lrdata, exp_rd[2]);
        check("timeout_err", 32'(bus.timeout_err), 32'(exp_terr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    bit [2:0] mask;
    bit       late;
    bus.dreq   = 1'b0;
    bus.dwe    = 1'b0;
    bus.daddr  = '0;
    bus.dwdata = '0;
    bus.ireq   = 1'b0;
    bus.iaddr  = '0;
    bus.lreq   = 1'b0;
    bus.lwe    = 1'b0;
    bus.laddr  = '0;
    bus.lwdata = '0;
    exp_rd[0]  = '0;
    exp_rd[1]  = '0;
    exp_rd[2]  = '0;
    exp_terr   = 1'b0;
    fav_fetch  = 1'b0;
    acc_cycles = 0;

    #7;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // data and fetch together straight out of reset: data first
    randomize_ops();
    op_lat[0] = 2;
    op_lat[1] = 1;
    start_batch(3'b011, 1'b0);
    finish_batch(1'b0);

    // single fetch read of 0x40
    randomize_ops();
    op_addr[1] = 32'h40;
    op_lat[1]  = 2;
    ref_mem[32'h40]   = 32'hDEAD_BEEF;
    mem_store[32'h40] = 32'hDEAD_BEEF;
    start_batch(3'b010, 1'b0);
    finish_batch(1'b0);
    check("fetch_read_0x40", bus.irdata, 32'hDEAD_BEEF);

    // data write
    randomize_ops();
    op_addr[0]  = 32'h100;
    op_we[0]    = 1'b1;
    op_wdata[0] = 32'h1234_5678;
    op_lat[0]   = 3;
    start_batch(3'b001, 1'b0);
    finish_batch(1'b0);

    // mem_ready on the last allowed cycle is a success
    randomize_ops();
    op_we[2]  = 1'b0;
    op_lat[2] = TO;
    start_batch(3'b100, 1'b0);
    finish_batch(1'b0);

    // loader raised mid-stream takes only the next grant
    randomize_ops();
    op_lat[0] = 1;
    op_lat[1] = 2;
    op_lat[2] = 1;
    start_batch(3'b011, 1'b1);
    finish_batch(1'b1);

    // all three at once
    randomize_ops();
    start_batch(3'b111, 1'b0);
    finish_batch(1'b0);

    // loader read with no mem_ready at all
    randomize_ops();
    op_we[2]  = 1'b0;
    op_lat[2] = 0;
    start_batch(3'b100, 1'b0);
    finish_batch(1'b0);

    // reset in the middle of an access that never completes
    randomize_ops();
    op_we[0]  = 1'b0;
    op_lat[0] = 0;
    start_batch(3'b001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    check("pre_reset_mem_en", 32'(bus.mem_en), 32'd1);
    apply_reset("mid_access");

    // a fresh data read completes normally after the abort
    randomize_ops();
    op_we[0]  = 1'b0;
    op_lat[0] = 1;
    start_batch(3'b001, 1'b0);
    finish_batch(1'b0);

    for (int b = 0; b < NBATCH; b++) begin
      randomize_ops();
      mask = 3'($urandom_range(1, 7));
      late = (mask == 3'b011) && ($urandom_range(0, 1) == 1);
      start_batch(mask, late);
      finish_batch(late);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    apply_reset("final");
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles an access waits for mem_ready (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-high.
REQ-004 dreq, dwe  input  1 each  data-port (MEM stage) request and write enable.
REQ-005 daddr, dwdata  input  32 each  data-port address and write data.
REQ-006 drdata  output 32, dack  output 1  data-port read data and one-cycle completion.
REQ-007 ireq  input 1, iaddr  input 32  fetch-port read request and address (read-only port).
REQ-008 irdata  output 32, iack  output 1  fetch-port read data and completion.
REQ-009 lreq, lwe  input 1 each; laddr, lwdata  input 32 each  loader/debug port request.
REQ-010 lrdata  output 32, lack  output 1  loader-port read data and completion.
REQ-011 mem_en, mem_we  output 1 each; mem_addr, mem_wdata  output 32 each  shared memory request.
REQ-012 mem_rdata  input 32, mem_ready  input 1  shared memory read data and completion.
REQ-013 busy  output 1  high whenever FSM is not IDLE.
REQ-014 timeout_err  output 1  sticky flag, set on any timed-out access.

Function
REQ-015 FSM states IDLE, ACCESS, DONE, encoded as registered state.
REQ-016 IDLE: at an edge with any req high, latch owner, address, wdata, we (we forced 0 for fetch); go ACCESS.
REQ-017 Priority: loader highest; dreq vs ireq resolved round-robin via 1-bit pointer.
REQ-018 Pointer after reset favours data; after granting data it favours fetch, after fetch it favours data; loader grants leave it unchanged.
REQ-019 ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata driven from latched values, stable for whole state.
REQ-020 ACCESS: on edge with mem_ready=1, capture mem_rdata (reads) or 0 (writes) into response register; go DONE.
REQ-021 ACCESS: wait counter increments each cycle without mem_ready; when counter reaches TIMEOUT, response=0, timeout_err set, go DONE.
REQ-022 mem_ready in the same cycle the counter would time out counts as success, not timeout.
REQ-023 DONE: owner's ack high exactly one cycle with owner's rdata valid; other acks low; next state IDLE unconditionally.
REQ-024 Each *rdata output holds its last response until that port's next ack; mem_en=0 in IDLE and DONE.
REQ-025 Minimum latency: request sampled at edge N -> ack high in cycle after edge N+2 (one-cycle mem_ready).
REQ-026 Requests are ignored outside IDLE; requesters hold req and operands stable until ack, then may drop or reissue.
REQ-027 Simultaneous dreq, ireq, lreq: loader served first; remaining two served in pointer order on subsequent IDLE visits.
REQ-028 mem_ready while not in ACCESS is ignored.

Reset
REQ-029 On reset assertion, immediately: state IDLE, all acks 0, mem_en/mem_we 0, mem_addr/mem_wdata 0.
REQ-030 On reset: all rdata registers 0, counter 0, pointer favours data, timeout_err 0, busy 0.
REQ-031 Reset mid-ACCESS abandons the transaction with no ack; requester must reissue.

Verification
REQ-032 Single read: ireq=1, iaddr=0x40, mem_ready next cycle with 0xDEADBEEF -> iack one cycle, irdata=0xDEADBEEF, two edges after sampling.
REQ-033 Contention: dreq and ireq held high from reset -> data served first, then fetch, alternating; loader raised mid-stream preempts next grant only.
REQ-034 Write: dreq=1, dwe=1, daddr=0x100, dwdata=0x12345678 -> mem_we=1 with those values throughout ACCESS; dack one cycle, drdata=0.
REQ-035 Timeout: lreq read, mem_ready never asserted -> lack after exactly TIMEOUT ACCESS cycles, lrdata=0, timeout_err=1 until reset.
REQ-036 Reset during ACCESS with mem_ready held low -> outputs zero immediately, no ack; after release a new dreq completes normally.
REQ-037 Boundary: mem_ready arrives on TIMEOUT-th cycle -> normal completion, timeout_err stays 0.
